// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: shares one ALU and one memory port across FETCH..WRITEBACK steps.
// Define ILLEGAL_TRAP_EN to trap illegal instructions in TRAP (adds illegal_instr); otherwise they run as NOPs.
module multicycle_control #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_a_src,
    output logic [1:0] alu_b_src,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] wb_src,
    output logic       instr_done,
    output logic       bus_err,
    output logic [3:0] state
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic       illegal_instr
`endif
);

    // FETCH/MEM_RD/MEM_WR wait on mem_ready; ERROR (bus timeout) and TRAP are terminal until reset.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13,
        S_ERROR    = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(WAIT_MAX);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_mem;
    logic             timeout;
    logic             r_legal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_mem  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign timeout = (WAIT_MAX != 0) && in_mem && !mem_ready && (cnt_q == CNT_LIM);
    assign r_legal = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h00) ||
                     (funct == 6'h02) || (funct == 6'h03);

    // Counter is held at zero outside the memory states, so entry always starts from zero.
    always_comb begin
        cnt_d = '0;
        if (in_mem && !mem_ready) begin
            cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        alu_a_src  = 1'b0;
        alu_b_src  = 2'd0;
        alu_op     = 2'd0;
        reg_write  = 1'b0;
        reg_dst    = 2'd0;
        wb_src     = 2'd0;
        instr_done = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_b_src = 2'd1;
                if (timeout) begin
                    state_d = S_ERROR;
                end else if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_b_src = 2'd3;
                if (op == 6'h00 && funct == 6'h08)      state_d = S_JR;
                else if (op == 6'h00 && r_legal)        state_d = S_EXEC_R;
                else if (op[5:3] == 3'b001)             state_d = S_EXEC_I;
                else if (op == 6'h23 || op == 6'h2b)    state_d = S_MEM_ADDR;
                else if (op == 6'h04 || op == 6'h05)    state_d = S_BRANCH;
                else if (op == 6'h02)                   state_d = S_JUMP;
                else if (op == 6'h03)                   state_d = S_JAL;
                else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
`endif
                end
            end
            S_EXEC_R: begin
                alu_a_src = 1'b1;
                alu_op    = 2'd2;
                state_d   = S_WB_R;
            end
            S_WB_R: begin
                reg_write  = 1'b1;
                reg_dst    = 2'd1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXEC_I: begin
                alu_a_src = 1'b1;
                alu_b_src = 2'd2;
                alu_op    = 2'd3;
                state_d   = S_WB_I;
            end
            S_WB_I: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_a_src = 1'b1;
                alu_b_src = 2'd2;
                state_d   = (op == 6'h2b) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (timeout)        state_d = S_ERROR;
                else if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                wb_src     = 2'd1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (timeout) begin
                    state_d = S_ERROR;
                end else if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_a_src  = 1'b1;
                alu_op     = 2'd1;
                pc_src     = 2'd1;
                pc_write   = ((op == 6'h04) && zero) || ((op == 6'h05) && !zero);
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 2'd2;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_src     = 2'd2;
                reg_write  = 1'b1;
                reg_dst    = 2'd2;
                wb_src     = 2'd2;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JR: begin
                pc_write   = 1'b1;
                pc_src     = 2'd3;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ERROR: state_d = S_ERROR;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase

        // Nothing architectural may be written while reset is held.
        if (reset) begin
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
        end
    end

    assign bus_err = (state_q == S_ERROR);
    assign state   = state_q;
`ifdef ILLEGAL_TRAP_EN
    assign illegal_instr = (state_q == S_TRAP);
`endif

endmodule
